// File: rtl/reg_file.sv
// 32x32 register file with two combinational read ports, one write port, and a
// registered last-write record plus write counter that feed the downstream bypass stage.
// Optional feature: define REGFILE_WRITE_BYPASS_EN for same-cycle write-through reads.
module reg_file (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [4:0]  ReadRegister1,
    input  logic [4:0]  ReadRegister2,
    output logic [31:0] RegisterData1,
    output logic [31:0] RegisterData2,
    input  logic [4:0]  WriteRegister,
    input  logic [31:0] WriteData,
    input  logic        WriteEnable,
    input  logic        Stall,
    output logic [4:0]  LastWriteRegister,
    output logic [31:0] LastWriteData,
    output logic        LastWriteValid,
    output logic [15:0] WriteCount
);

    logic [31:0] mem_q [32];
    logic        eff_wr_s;
    logic        last_valid_q, last_valid_d;
    logic [4:0]  last_reg_q, last_reg_d;
    logic [31:0] last_data_q, last_data_d;
    logic [15:0] count_q, count_d;
    logic [31:0] rd1_s, rd2_s;

    // Writes to entry 0 and writes under reset never count as effective
    always_comb begin
        eff_wr_s = 1'b0;
        if (RESET && WriteEnable && (WriteRegister != 5'd0)) begin
            eff_wr_s = 1'b1;
        end else begin
            eff_wr_s = 1'b0;
        end
    end

    // Read port 1 (entry 0 hardwired to zero)
    always_comb begin
        rd1_s = 32'd0;
        if (ReadRegister1 == 5'd0) begin
            rd1_s = 32'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
        end else if (eff_wr_s && (WriteRegister == ReadRegister1)) begin
            rd1_s = WriteData;
`endif
        end else begin
            rd1_s = mem_q[ReadRegister1];
        end
    end

    // Read port 2 (entry 0 hardwired to zero)
    always_comb begin
        rd2_s = 32'd0;
        if (ReadRegister2 == 5'd0) begin
            rd2_s = 32'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
        end else if (eff_wr_s && (WriteRegister == ReadRegister2)) begin
            rd2_s = WriteData;
`endif
        end else begin
            rd2_s = mem_q[ReadRegister2];
        end
    end

    // Last-write record and counter advance only on unstalled edges
    always_comb begin
        last_valid_d = last_valid_q;
        last_reg_d   = last_reg_q;
        last_data_d  = last_data_q;
        count_d      = count_q;
        if (!Stall) begin
            last_valid_d = eff_wr_s;
            if (eff_wr_s) begin
                last_reg_d  = WriteRegister;
                last_data_d = WriteData;
                count_d     = count_q + 16'd1;
            end else begin
                last_reg_d  = last_reg_q;
                last_data_d = last_data_q;
                count_d     = count_q;
            end
        end else begin
            last_valid_d = last_valid_q;
        end
    end

    // State update; reset wins over any write or stall presented on the same edge
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            for (int i = 0; i < 32; i++) begin
                mem_q[i] <= 32'd0;
            end
            last_valid_q <= 1'b0;
            last_reg_q   <= 5'd0;
            last_data_q  <= 32'd0;
            count_q      <= 16'd0;
        end else begin
            if (eff_wr_s) begin
                mem_q[WriteRegister] <= WriteData;
            end
            last_valid_q <= last_valid_d;
            last_reg_q   <= last_reg_d;
            last_data_q  <= last_data_d;
            count_q      <= count_d;
        end
    end

    assign RegisterData1     = rd1_s;
    assign RegisterData2     = rd2_s;
    assign LastWriteValid    = last_valid_q;
    assign LastWriteRegister = last_reg_q;
    assign LastWriteData     = last_data_q;
    assign WriteCount        = count_q;

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus pushes expected responses from an array
// model, a negedge monitor pops and compares them against the DUT outputs.
module tb_reg_file;

    logic        CLK;
    logic        RESET;
    logic [4:0]  ReadRegister1, ReadRegister2, WriteRegister;
    logic [31:0] RegisterData1, RegisterData2, WriteData, LastWriteData;
    logic        WriteEnable, Stall, LastWriteValid;
    logic [4:0]  LastWriteRegister;
    logic [15:0] WriteCount;

    reg_file dut (
        .CLK(CLK), .RESET(RESET),
        .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
        .RegisterData1(RegisterData1), .RegisterData2(RegisterData2),
        .WriteRegister(WriteRegister), .WriteData(WriteData),
        .WriteEnable(WriteEnable), .Stall(Stall),
        .LastWriteRegister(LastWriteRegister), .LastWriteData(LastWriteData),
        .LastWriteValid(LastWriteValid), .WriteCount(WriteCount)
    );

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        lwv;
        logic [4:0]  lwr;
        logic [31:0] lwd;
        logic [15:0] wc;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];

    int checks   = 0;
    int failures = 0;
    bit stim_done = 1'b0;

    // reference model state
    logic [31:0] m_mem [32];
    logic        m_lwv;
    logic [4:0]  m_lwr;
    logic [31:0] m_lwd;
    int          m_cnt;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic cmp(input string nm, input string field, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s.%s got=%h expected=%h", nm, field, got, want);
        end
    endtask

    // monitor: outputs are stable at the falling edge
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(negedge CLK);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                cmp(nm, "RegisterData1", RegisterData1, e.rd1);
                cmp(nm, "RegisterData2", RegisterData2, e.rd2);
                cmp(nm, "LastWriteValid", {31'd0, LastWriteValid}, {31'd0, e.lwv});
                cmp(nm, "LastWriteRegister", {27'd0, LastWriteRegister}, {27'd0, e.lwr});
                cmp(nm, "LastWriteData", LastWriteData, e.lwd);
                cmp(nm, "WriteCount", {16'd0, WriteCount}, {16'd0, e.wc});
            end
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] ra, input bit eff,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (ra == 5'd0) return 32'd0;
`ifdef REGFILE_WRITE_BYPASS_EN
        if (eff && (wa == ra)) return wd;
`endif
        return m_mem[ra];
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 32'd0;
        m_lwv = 1'b0;
        m_lwr = 5'd0;
        m_lwd = 32'd0;
        m_cnt = 0;
    endfunction

    // one clock cycle: drive, predict, let the edge happen, advance the model
    task automatic step(input logic rst, input logic we, input logic stl,
                        input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra1, input logic [4:0] ra2, input string nm);
        exp_t e;
        bit   eff;
        RESET = rst; WriteEnable = we; Stall = stl;
        WriteRegister = wa; WriteData = wd;
        ReadRegister1 = ra1; ReadRegister2 = ra2;
        eff = (rst == 1'b1) && (we == 1'b1) && (wa != 5'd0);
        e.rd1 = model_read(ra1, eff, wa, wd);
        e.rd2 = model_read(ra2, eff, wa, wd);
        e.lwv = m_lwv;
        e.lwr = m_lwr;
        e.lwd = m_lwd;
        e.wc  = m_cnt[15:0];
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge CLK);
        if (!rst) begin
            model_reset();
        end else begin
            if (eff) m_mem[wa] = wd;
            if (!stl) begin
                m_lwv = eff;
                if (eff) begin
                    m_lwr = wa;
                    m_lwd = wd;
                    m_cnt = (m_cnt + 1) % 65536;
                end
            end
        end
        #1;
    endtask

    initial begin
        RESET = 1'b0; WriteEnable = 1'b0; Stall = 1'b0;
        WriteRegister = 5'd0; WriteData = 32'd0;
        ReadRegister1 = 5'd0; ReadRegister2 = 5'd0;
        repeat (2) @(posedge CLK);
        #1;
        model_reset();

        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd31, "post_reset");
        step(1'b1, 1'b1, 1'b0, 5'd5, 32'h12345678, 5'd5, 5'd0, "rst_write_r5");
        step(1'b0, 1'b1, 1'b1, 5'd6, 32'hCAFEF00D, 5'd5, 5'd6, "rst_edge");
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd6, "rst_read_r5");

        step(1'b1, 1'b1, 1'b0, 5'd7, 32'hDEADBEEF, 5'd0, 5'd7, "write_r7");
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7, "read_r7");

        step(1'b1, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, "write_r0");
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd7, "read_r0");

        step(1'b1, 1'b1, 1'b0, 5'd3, 32'h00000001, 5'd0, 5'd0, "r3_init");
        step(1'b1, 1'b1, 1'b0, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd3, "collision");
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0, "after_collision");

        step(1'b1, 1'b1, 1'b1, 5'd9, 32'h00000055, 5'd9, 5'd0, "stall_write_r9");
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd3, "stall_read_r9");

        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(63) != 0), ($urandom_range(3) != 0), ($urandom_range(3) == 0),
                 5'($urandom_range(31)), $urandom(),
                 5'($urandom_range(31)), 5'($urandom_range(31)), "random");
        end

        step(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, "wrap_reset");
        for (int i = 0; i < 65536; i++) begin
            step(1'b1, 1'b1, 1'b0, 5'(1 + (i % 31)), i, 5'(1 + ((i + 7) % 31)), 5'd0, "wrap_writes");
        end
        step(1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd31, "wrap_count");

        stim_done = 1'b1;
        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending=%0d expected=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port RESET, input, 1 bit: reset, synchronous, active-low.
REQ-003 SHALL have ports ReadRegister1 and ReadRegister2, input, 5 bits each: read addresses for ports 1 and 2.
REQ-004 SHALL have ports RegisterData1 and RegisterData2, output, 32 bits each: combinational read data for ports 1 and 2.
REQ-005 SHALL have port WriteRegister, input, 5 bits: write address from writeback.
REQ-006 SHALL have port WriteData, input, 32 bits: write data.
REQ-007 SHALL have port WriteEnable, input, 1 bit: write request qualifier.
REQ-008 SHALL have port Stall, input, 1 bit: freezes LastWrite* outputs and WriteCount; does not block array writes.
REQ-009 SHALL have ports LastWriteRegister, output, 5 bits, and LastWriteData, output, 32 bits: registered copy of the most recent effective write, feeding the bypass stage.
REQ-010 SHALL have port LastWriteValid, output, 1 bit: qualifies LastWriteRegister and LastWriteData.
REQ-011 SHALL have port WriteCount, output, 16 bits: count of effective writes.

Function
REQ-012 SHALL hold 32 entries of 32 bits; entry 0 reads 0 at all times and is never written.
REQ-013 SHALL define an effective write as WriteEnable=1 and WriteRegister!=0 while RESET=1.
REQ-014 SHALL update the array entry at the clock edge after an effective write, giving 1-cycle write latency.
REQ-015 SHALL return RegisterDataN = entry[ReadRegisterN] combinationally, with no registered read latency.
REQ-016 SHALL update the LastWrite* outputs on each edge with Stall=0:
- LastWriteValid <= effective write
- LastWriteRegister <= WriteRegister
- LastWriteData <= WriteData
- Register and Data are updated only when the write is effective; otherwise they hold.
REQ-017 SHALL hold all LastWrite* outputs unchanged on an edge with Stall=1.
REQ-018 SHALL increment WriteCount by 1 per effective write when Stall=0, wrapping from 0xFFFF to 0x0000.
REQ-019 SHALL perform a simultaneous read and write of the same address as follows:
- Without the Configuration macro, the read returns the old value.
- With it, see REQ-024.
REQ-020 SHALL treat a write with WriteRegister=0 as a no-op: no array change, LastWriteValid=0, no count.

Reset
REQ-021 SHALL, on an edge with RESET=0, clear in that single cycle:
- all 32 entries to 0
- LastWriteRegister, LastWriteData and LastWriteValid to 0
- WriteCount to 0
REQ-022 SHALL give reset priority over WriteEnable and Stall; a write presented during reset is lost.
REQ-023 SHALL make all outputs read 0 in the cycle after reset, including reads from any address.

Configuration
REQ-024 SHALL provide internal write-through bypass when macro REGFILE_WRITE_BYPASS_EN is defined:
- If an effective write is present and WriteRegister==ReadRegisterN, RegisterDataN = WriteData in the same cycle.
- Address 0 still reads 0.
REQ-025 SHALL, when REGFILE_WRITE_BYPASS_EN is undefined, provide no internal bypass; same-cycle forwarding is left to the downstream bypass stage using LastWrite* and the writeback signals.

Verification
REQ-026 SHALL pass a reset test:
- Stimulus: write r5=0x12345678; then RESET=0 for one edge; read r5.
- Required response: RegisterData1=0, WriteCount=0, LastWriteValid=0.
REQ-027 SHALL pass a basic write/read test:
- Stimulus: write r7=0xDEADBEEF; next cycle ReadRegister2=7.
- Required response: RegisterData2=0xDEADBEEF, LastWriteRegister=7, LastWriteValid=1, WriteCount=1.
REQ-028 SHALL pass an r0 test:
- Stimulus: WriteEnable=1, WriteRegister=0, WriteData=0xFFFFFFFF; read r0.
- Required response: 0; LastWriteValid=0; WriteCount unchanged.
REQ-029 SHALL pass a same-cycle collision test:
- Stimulus: write r3=0xA5A5A5A5 while ReadRegister1=3, with r3 previously 0x1.
- Required response: RegisterData1=0x1 without REGFILE_WRITE_BYPASS_EN; 0xA5A5A5A5 with it.
REQ-030 SHALL pass a stall test:
- Stimulus: Stall=1; write r9=0x55.
- Required response: r9 reads 0x55 next cycle; LastWrite* and WriteCount unchanged from before the write.
REQ-031 SHALL pass a wrap test:
- Stimulus: 65536 effective writes after reset.
- Required response: WriteCount=0x0000.
